// File: rtl/nanov_spi_fetch.sv
// SPI flash instruction fetcher: issues READ (or FAST READ when NANOV_FETCH_FAST_READ_EN
// is defined) and streams little-endian 32-bit words through a single output register.
module nanov_spi_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] addr,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [2:0] {IDLE, GAP, CMD, ADDR, DUMMY, DATA} state_t;

`ifdef NANOV_FETCH_FAST_READ_EN
    localparam logic [7:0] CMD_BYTE   = 8'h0B;
    localparam state_t     AFTER_ADDR = DUMMY;
`else
    localparam logic [7:0] CMD_BYTE   = 8'h03;
    localparam state_t     AFTER_ADDR = DATA;
`endif

    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(23);
    localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(31);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   tx_q, tx_d;
    logic [WORD_W-1:0]   rx_q, rx_d;
    logic                stall_q, stall_d;
    logic                cs_n_q, cs_n_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic [WORD_W-1:0]   instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic [WORD_W-1:0]   tx_word_c;
    logic                word_done_c;
    logic                handshake_c;
    logic                unused_addr_lsbs;

    // Word address only; the two byte-offset bits are forced to zero on the wire.
    assign unused_addr_lsbs = ^addr[1:0];
    assign tx_word_c        = {CMD_BYTE, addr[23:2], 2'b00};
    assign handshake_c      = valid_q && instr_ready;

    // Bytes arrive in address order into the top of rx; reverse them for little-endian.
    function automatic logic [WORD_W-1:0] swap_bytes(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        stall_d     = stall_q;
        cs_n_d      = cs_n_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        word_done_c = 1'b0;

        if (start) begin
            valid_d = 1'b0;
            stall_d = 1'b0;
            sck_d   = 1'b0;
            cnt_d   = '0;
            rx_d    = '0;
            if (state_q == IDLE) begin
                state_d = CMD;
                cs_n_d  = 1'b0;
                mosi_d  = tx_word_c[WORD_W-1];
                tx_d    = {tx_word_c[WORD_W-2:0], 1'b0};
            end else begin
                state_d = GAP;
                cs_n_d  = 1'b1;
                mosi_d  = 1'b0;
                tx_d    = tx_word_c;
            end
        end else begin
            case (state_q)
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = CMD;
                        cnt_d   = '0;
                        cs_n_d  = 1'b0;
                        mosi_d  = tx_q[WORD_W-1];
                        tx_d    = {tx_q[WORD_W-2:0], 1'b0};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CMD, ADDR, DUMMY, DATA: begin
                    if (!sck_q) begin
                        // A stalled word keeps SCK parked in its low phase.
                        if (!stall_q) sck_d = 1'b1;
                    end else begin
                        sck_d  = 1'b0;
                        mosi_d = tx_q[WORD_W-1];
                        tx_d   = {tx_q[WORD_W-2:0], 1'b0};
                        cnt_d  = cnt_q + CNT_W'(1);
                        case (state_q)
                            CMD: if (cnt_q == CMD_LAST) begin
                                state_d = ADDR;
                                cnt_d   = '0;
                            end
                            ADDR: if (cnt_q == ADDR_LAST) begin
                                state_d = AFTER_ADDR;
                                cnt_d   = '0;
                            end
                            DUMMY: if (cnt_q == DUMMY_LAST) begin
                                state_d = DATA;
                                cnt_d   = '0;
                            end
                            default: begin
                                rx_d        = {rx_q[WORD_W-2:0], spi_miso};
                                word_done_c = (cnt_q == DATA_LAST);
                            end
                        endcase
                    end
                end
                default: ;
            endcase

            if (word_done_c) begin
                if (!valid_q || instr_ready) begin
                    instr_d = swap_bytes(rx_d);
                    valid_d = 1'b1;
                end else begin
                    stall_d = 1'b1;
                end
            end else if (handshake_c) begin
                if (stall_q) begin
                    instr_d = swap_bytes(rx_q);
                    stall_d = 1'b0;
                end else begin
                    valid_d = 1'b0;
                end
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            stall_q <= 1'b0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            instr_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            stall_q <= stall_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign busy        = busy_q;
    assign spi_cs_n    = cs_n_q;
    assign spi_sck     = sck_q;
    assign spi_mosi    = mosi_q;

endmodule

// File: tb/tb_nanov_spi_fetch.sv
// Directed bench for nanov_spi_fetch with a cycle-level SPI flash model.
module tb_nanov_spi_fetch;

`ifdef NANOV_FETCH_FAST_READ_EN
    localparam int          HDR   = 40;
    localparam int          LAT   = 145;
    localparam logic [7:0]  CMDB  = 8'h0B;
`else
    localparam int          HDR   = 32;
    localparam int          LAT   = 129;
    localparam logic [7:0]  CMDB  = 8'h03;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] addr = 24'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        busy;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    int checks = 0;
    int errors = 0;

    nanov_spi_fetch dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .busy(busy), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    // Flash contents: a known instruction at 0x100, a simple ramp elsewhere.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h13;
            24'h000101: return 8'h05;
            24'h000102: return 8'h10;
            24'h000103: return 8'h00;
            default:    return 8'(a[7:0] + 8'h31);
        endcase
    endfunction

    int          m_cnt = 0;
    int          m_dummy_ones = 0;
    logic [31:0] m_hdr = 32'h0;
    logic        m_prev_sck = 1'b0;

    // Flash model: captures MOSI after each SCK rise, presents MISO during low phases.
    always @(negedge clk) begin
        int          idx;
        logic [23:0] a;
        logic [7:0]  b;
        if (spi_cs_n) begin
            m_cnt        = 0;
            m_dummy_ones = 0;
        end else begin
            if (spi_sck && !m_prev_sck) begin
                if (m_cnt < 32) m_hdr = {m_hdr[30:0], spi_mosi};
                else if (m_cnt < HDR) m_dummy_ones = m_dummy_ones + int'(spi_mosi);
                m_cnt = m_cnt + 1;
            end
            if (!spi_sck) begin
                idx = m_cnt - HDR;
                if (idx >= 0) begin
                    a = 24'(m_hdr[23:0] + 24'(idx / 8));
                    b = mem_byte(a);
                    spi_miso = b[7 - (idx % 8)];
                end
            end
        end
        m_prev_sck = spi_sck;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int first, input int limit, output int lat);
        lat = first;
        while (!instr_valid && lat < limit) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int highs;
        int r0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n",  32'(spi_cs_n), 32'd1);
        chk("rst_sck",   32'(spi_sck), 32'd0);
        chk("rst_mosi",  32'(spi_mosi), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // First fetch from IDLE
        start = 1'b1; addr = 24'h000100;
        @(negedge clk);
        start = 1'b0;
        chk("t1_cs_n", 32'(spi_cs_n), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_valid(1, 400, lat);
        chk("first_lat",   32'(lat), 32'(LAT));
        chk("first_instr", instr, 32'h00100513);
        chk("first_hdr",   m_hdr, {CMDB, 24'h000100});
`ifdef NANOV_FETCH_FAST_READ_EN
        chk("dummy_ones", 32'(m_dummy_ones), 32'd0);
`endif

        // Consumer stalls: second word completes and SCK parks low
        highs = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i >= 100 && spi_sck) highs++;
        end
        chk("stall_sck_highs", 32'(highs), 32'd0);
        chk("stall_instr", instr, 32'h00100513);
        chk("stall_valid", 32'(instr_valid), 32'd1);
        chk("stall_cs_n",  32'(spi_cs_n), 32'd0);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("release_instr", instr, 32'h38373635);
        chk("release_valid", 32'(instr_valid), 32'd1);
        chk("release_sck0",  32'(spi_sck), 32'd0);
        @(negedge clk);
        chk("release_sck1",  32'(spi_sck), 32'd1);

        // Abort in the middle of the third data byte
        repeat (39) @(negedge clk);
        start = 1'b1; addr = 24'h000203; instr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_cs_n",  32'(spi_cs_n), 32'd1);
        chk("abort_sck",   32'(spi_sck), 32'd0);
        chk("abort_valid", 32'(instr_valid), 32'd0);
        chk("abort_busy",  32'(busy), 32'd1);
        @(negedge clk);
        chk("gap2_cs_n", 32'(spi_cs_n), 32'd1);
        @(negedge clk);
        chk("gap_end_cs_n", 32'(spi_cs_n), 32'd0);
        wait_valid(3, 400, lat);
        chk("abort_lat",   32'(lat), 32'(LAT + 2));
        chk("abort_instr", instr, 32'h34333231);
        chk("abort_hdr",   m_hdr, {CMDB, 24'h000200});

        // Streaming with ready held high
        r0 = m_cnt;
        @(negedge clk);
        chk("pulse_low", 32'(instr_valid), 32'd0);
        wait_valid(1, 200, lat);
        chk("w1_lat", 32'(lat), 32'd64);
        chk("w1_instr", instr, 32'h38373635);
        @(negedge clk);
        wait_valid(1, 200, lat);
        chk("w2_lat", 32'(lat), 32'd64);
        chk("w2_instr", instr, 32'h3c3b3a39);
        @(negedge clk);
        wait_valid(1, 200, lat);
        chk("w3_lat", 32'(lat), 32'd64);
        chk("w3_instr", instr, 32'h403f3e3d);
        chk("stream_rises", 32'(m_cnt - r0), 32'd96);

        // Reset mid-stream, then reset together with start in the ADDR phase
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_cs_n",  32'(spi_cs_n), 32'd1);
        chk("rst2_valid", 32'(instr_valid), 32'd0);
        instr_ready = 1'b0;
        start = 1'b1; addr = 24'h000100;
        @(negedge clk);
        start = 1'b0;
        repeat (28) @(negedge clk);
        rst = 1'b1; start = 1'b1; addr = 24'h000300;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst3_cs_n",  32'(spi_cs_n), 32'd1);
        chk("rst3_sck",   32'(spi_sck), 32'd0);
        chk("rst3_valid", 32'(instr_valid), 32'd0);
        chk("rst3_busy",  32'(busy), 32'd0);
        highs = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (spi_sck || !spi_cs_n) highs++;
        end
        chk("post_rst_activity", 32'(highs), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nanov_spi_fetch.md
NANOV_SPI_FETCH -- requirements
Module: nanoV_spi_fetch

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-002 clk  in  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 start  in  1  one-cycle request to begin fetching at addr; SHALL be accepted in any state.
REQ-005 addr  in  24  byte address of the first instruction word; addr[1:0] SHALL be ignored and treated as 00.
REQ-006 instr  out  32  fetched instruction word; byte at lowest address SHALL be in instr[7:0] (little-endian).
REQ-007 instr_valid  out  1  instr holds an unconsumed word.
REQ-008 instr_ready  in  1  core consumes instr when instr_valid && instr_ready on a clock edge.
REQ-009 busy  out  1  high whenever spi_cs_n is low or a deselect gap is in progress.
REQ-010 spi_cs_n  out  1  SPI chip select, active low.
REQ-011 spi_sck  out  1  SPI clock, mode 0, idle low.
REQ-012 spi_mosi  out  1  SPI data to memory.
REQ-013 spi_miso  in  1  SPI data from memory.

Function
REQ-014 The state machine SHALL have the states IDLE, GAP, CMD, ADDR, DUMMY and DATA, with a 5-bit bit counter per phase.
REQ-015 spi_sck SHALL run at clk/2, each SPI bit taking 2 cycles: a low phase, then a high phase.
REQ-016 spi_mosi SHALL change only at the start of a low phase.
REQ-017 spi_miso SHALL be sampled on the clk edge that ends a high phase.
REQ-018 From IDLE, a start accepted at edge T SHALL drive spi_cs_n low from cycle T+1, then shift the command byte in CMD, then addr[23:0] with addr[1:0] forced to 00 in ADDR, all MSB first.
REQ-019 In DATA, each byte SHALL be received MSB first; four bytes SHALL form one word, assembled little-endian.
REQ-020 The first word SHALL appear with instr_valid high at cycle T+129.
REQ-021 After the first word, DATA SHALL stream continuously, relying on memory auto-increment; one word SHALL complete every 64 cycles while unstalled.
REQ-022 Buffering SHALL be one output register (instr) plus one shift register.
REQ-023 When a word completes and instr_valid is low, or a handshake occurs in that same cycle, the word SHALL move to instr with instr_valid high on the next cycle and no SCK pause.
REQ-024 When a word completes while instr is still unconsumed, spi_sck SHALL be held low and the completed word retained until the handshake.
REQ-025 That stalled word SHALL transfer to instr on the handshake edge, and SCK SHALL resume on the following cycle.
REQ-026 A handshake with no completed word pending SHALL clear instr_valid on the next cycle.
REQ-027 A start while busy SHALL abort: next cycle spi_cs_n high, spi_sck low, instr_valid low, partial word discarded.
REQ-028 After an abort, GAP SHALL hold spi_cs_n high for 2 cycles, then begin CMD with the new addr; first instr_valid SHALL appear at T+131.
REQ-029 If start and a handshake occur in the same cycle, start SHALL win and the held word SHALL be dropped.
REQ-030 The memory address SHALL wrap from 0xFFFFFC to 0x000000 per device behaviour; the block SHALL take no action at the wrap.
REQ-031 instr SHALL remain stable while instr_valid is high and no handshake or start occurs.

Reset
REQ-032 On rst, the next cycle SHALL have: spi_cs_n=1, spi_sck=0, spi_mosi=0, instr=0, instr_valid=0, busy=0, state IDLE.
REQ-033 rst SHALL override start in the same cycle.
REQ-034 Reset mid-transfer SHALL deselect the memory with no GAP requirement.

Configuration
REQ-035 NANOV_FETCH_FAST_READ_EN undefined: the command SHALL be 0x03 (READ), with no DUMMY phase and first-word latency T+129 (T+131 after abort).
REQ-036 NANOV_FETCH_FAST_READ_EN defined: the command SHALL be 0x0B (FAST READ), followed by 8 DUMMY bits with spi_mosi=0, and first-word latency T+145 (T+147 after abort).

Verification
REQ-037 Reset, then start with addr=0x000100 and a memory model returning 0x13,0x05,0x10,0x00 -> MOSI carries 0x03 then 0x000100; instr=0x00100513 with instr_valid high at T+129.
REQ-038 instr_ready held high, 4 words -> spi_sck never pauses; instr_valid pulses at T+129+64k for k=0..3, each word correct.
REQ-039 instr_ready held low for 200 cycles after the first word -> second word completes, spi_sck held low; on ready, instr updates next edge and SCK resumes after.
REQ-040 Start with addr=0x000203 in the middle of the 3rd data byte -> cs_n high 2 cycles, instr_valid low, address sent 0x000200, first new word at T+131.
REQ-041 rst asserted in the ADDR phase together with start -> cs_n=1, sck=0, instr_valid=0 next cycle; no further SPI activity.
REQ-042 With NANOV_FETCH_FAST_READ_EN defined, repeat REQ-037 -> command 0x0B, 8 dummy bits, instr valid at T+145.
